// File: rtl/sm_dbg_dump.sv
// Debug readout engine: dumps all register slots (and, with SM_DBG_DUMP_MEM_EN,
// all data-RAM words) of the core as a UART 8N1 frame led by sync byte 0xA5.
module sm_dbg_dump #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [3:0]  memAddr,
  input  logic [31:0] memData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, FIN} state_t;

  state_t          state;
  logic [4:0]      idx;
  logic [1:0]      byte_cnt;
  logic [3:0]      bit_cnt;
  logic [BW-1:0]   baud_cnt;
  logic [7:0]      shreg;
  logic [31:0]     word;
  logic            sync_byte;
  logic            last_word_c;
  logic [31:0]     cap_word_c;
  logic            baud_end_c;

  assign baud_end_c = (baud_cnt == BW'(BAUD_DIV - 1));

`ifdef SM_DBG_DUMP_MEM_EN
  logic mem_phase;
  assign last_word_c = mem_phase && (idx[3:0] == 4'd15);
  assign cap_word_c  = mem_phase ? memData : regData;
`else
  logic unused_mem_data;
  assign unused_mem_data = ^memData;
  assign memAddr         = 4'd0;
  assign last_word_c     = (idx == 5'd31);
  assign cap_word_c      = regData;
`endif

  // Frame sequencer; the sync byte is loaded on the start edge so its start bit
  // leaves the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 5'd0;
      byte_cnt  <= 2'd0;
      bit_cnt   <= 4'd0;
      baud_cnt  <= '0;
      shreg     <= 8'd0;
      word      <= 32'd0;
      sync_byte <= 1'b0;
      regAddr   <= 5'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SM_DBG_DUMP_MEM_EN
      mem_phase <= 1'b0;
      memAddr   <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (start) begin
            state     <= SEND;
            busy      <= 1'b1;
            tx        <= 1'b0;
            shreg     <= SYNC_BYTE;
            sync_byte <= 1'b1;
            bit_cnt   <= 4'd0;
            baud_cnt  <= '0;
            idx       <= 5'd0;
`ifdef SM_DBG_DUMP_MEM_EN
            mem_phase <= 1'b0;
`endif
          end
        end
        ADDR: state <= CAPT;
        CAPT: begin
          // RAM data is valid here, one clock after its address was driven
          word     <= cap_word_c;
          shreg    <= cap_word_c[7:0];
          byte_cnt <= 2'd0;
          bit_cnt  <= 4'd0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= SEND;
        end
        SEND: begin
          if (!baud_end_c) begin
            baud_cnt <= baud_cnt + BW'(1);
          end else begin
            baud_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              // Shifting in ones makes the stop bit fall out after the data bits
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[7:1]};
            end else begin
              bit_cnt <= 4'd0;
              if (!sync_byte && byte_cnt != 2'd3) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= word[15:8];
                word     <= {8'h00, word[31:8]};
                tx       <= 1'b0;
              end else if (sync_byte) begin
                sync_byte <= 1'b0;
                regAddr   <= 5'd0;
                state     <= ADDR;
              end else if (last_word_c) begin
                state <= FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ADDR;
`ifdef SM_DBG_DUMP_MEM_EN
                if (mem_phase) begin
                  idx     <= idx + 5'd1;
                  memAddr <= idx[3:0] + 4'd1;
                end else if (idx == 5'd31) begin
                  mem_phase <= 1'b1;
                  idx       <= 5'd0;
                  memAddr   <= 4'd0;
                end else begin
                  idx     <= idx + 5'd1;
                  regAddr <= idx + 5'd1;
                end
`else
                idx     <= idx + 5'd1;
                regAddr <= idx + 5'd1;
`endif
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_dbg_dump.sv
// Bench for sm_dbg_dump: random register/RAM contents, UART line decoded and
// compared with a frame built directly from the byte layout.
module tb_sm_dbg_dump;

  localparam int unsigned BAUD = 4;
`ifdef SM_DBG_DUMP_MEM_EN
  localparam int NWORDS = 48;
`else
  localparam int NWORDS = 32;
`endif
  localparam int NBYTES    = 1 + 4 * NWORDS;
  localparam int FRAME_CYC = NBYTES * 10 * BAUD + NWORDS * 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [3:0]  memAddr;
  logic [31:0] memData = 32'd0;
  logic        tx, busy, done;

  logic [31:0] reg_model [32];
  logic [31:0] mem_model [16];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_start = 0;
  int done_cyc = 0;
  int mem_nz = 0;

  sm_dbg_dump #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .regAddr(regAddr), .regData(regData),
    .memAddr(memAddr), .memData(memData),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core-side models: combinational register port, registered RAM port
  assign regData = reg_model[regAddr];
  always @(posedge clk) memData <= mem_model[memAddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver sampling mid-bit
  bit         rx_active = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'd0;
  always @(negedge clk) begin
    if (memAddr != 4'd0) mem_nz++;
    if (!rst_n) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_t = 0;
          if (rx_q.size() == 0) first_start = cyc;
        end
      end else begin
        rx_t++;
      end
      if (rx_active && (rx_t % BAUD) == BAUD / 2) begin
        if (rx_t / BAUD == 0) chk("start_bit", 32'(tx), 32'd0);
        else if (rx_t / BAUD <= 8) rx_byte[rx_t / BAUD - 1] = tx;
        else begin
          chk("stop_bit", 32'(tx), 32'd1);
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic prep_frame();
    for (int i = 0; i < 32; i++) reg_model[i] = $urandom;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    reg_model[1] = 32'h11223344;
    mem_model[3] = 32'hDEADBEEF;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int w = 0; w < 32; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((reg_model[w] >> (8 * b)) & 32'hFF));
`ifdef SM_DBG_DUMP_MEM_EN
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((mem_model[w] >> (8 * b)) & 32'hFF));
`endif
    rx_q.delete();
  endtask

  task automatic begin_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("tx_sync_start_bit", 32'(tx), 32'd0);
  endtask

  task automatic wait_bytes(input int n);
    int i;
    i = 0;
    while (rx_q.size() < n && i < FRAME_CYC + 100) begin
      @(negedge clk);
      i++;
    end
    if (rx_q.size() < n) chk("wait_bytes_timeout", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_CYC + 100 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    chk({tag, "_len"}, 32'(done_cyc - first_start), 32'(FRAME_CYC));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    rx_q.delete();
  endtask

  initial begin
    bit ok;
    int extra;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_regaddr", 32'(regAddr), 32'd0);
      chk("rst_memaddr", 32'(memAddr), 32'd0);
    end

    // Frame with a start re-pulse at byte 10
    prep_frame();
    begin_frame();
    wait_bytes(10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(ok);
    if (ok) check_frame("f1");
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("f1_done_once", 32'(extra), 32'd0);
    chk("f1_idle_after", 32'(busy), 32'd0);
    chk("f1_no_extra_bytes", 32'(rx_q.size()), 32'd0);

    // Reset during byte 50, then a complete frame
    prep_frame();
    begin_frame();
    wait_bytes(50);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    prep_frame();
    begin_frame();
    wait_done(ok);
    if (ok) check_frame("f3");

    // Start held high across FIN: back-to-back frames
    prep_frame();
    begin_frame();
    wait_bytes(20);
    @(negedge clk) start = 1'b1;
    wait_done(ok);
    if (ok) begin
      check_frame("f4");
      prep_frame();
      @(negedge clk);
      chk("b2b_tx", 32'(tx), 32'd0);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done", 32'(done), 32'd0);
      start = 1'b0;
      wait_done(ok);
      if (ok) check_frame("f5");
    end
    start = 1'b0;

`ifndef SM_DBG_DUMP_MEM_EN
    chk("memaddr_tied", 32'(mem_nz), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
